// File: rtl/fme_refine_ctrl.sv
// Fractional motion-estimation sequencer: a half-pel pass of 9 candidates, then a
// quarter-pel pass around the half-pel winner, tracking the minimum-cost vector.
module fme_refine_ctrl #(
  parameter int MVW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MVW-3:0]    int_mv_x,
  input  logic [MVW-3:0]    int_mv_y,
  output logic              cand_valid,
  input  logic              cand_ready,
  output logic [MVW-1:0]    cand_mv_x,
  output logic [MVW-1:0]    cand_mv_y,
  input  logic              cost_valid,
  input  logic [15:0]       cost,
  output logic              busy,
  output logic              done,
  output logic [MVW-1:0]    best_mv_x,
  output logic [MVW-1:0]    best_mv_y,
  output logic [15:0]       best_cost
);

  typedef enum logic [1:0] {IDLE, HALF, QTR, DONE} state_t;

  typedef struct packed {
    logic [MVW-1:0] x;
    logic [MVW-1:0] y;
  } mv_t;

  localparam logic [3:0] NCAND = 4'd9;

  // Candidate k of the 3x3 ring around c; index 8 (and anything beyond) is the centre.
  function automatic mv_t cand_at(input mv_t c, input logic half, input logic [3:0] k);
    logic signed [2:0]     dx;
    logic signed [2:0]     dy;
    logic signed [MVW-1:0] ox;
    logic signed [MVW-1:0] oy;
    mv_t                   r;
    dx = 3'sd0;
    dy = 3'sd0;
    case (k)
      4'd0: begin dx = -3'sd1; dy = -3'sd1; end
      4'd1: dy = -3'sd1;
      4'd2: begin dx = 3'sd1;  dy = -3'sd1; end
      4'd3: dx = -3'sd1;
      4'd4: dx = 3'sd1;
      4'd5: begin dx = -3'sd1; dy = 3'sd1; end
      4'd6: dy = 3'sd1;
      4'd7: begin dx = 3'sd1;  dy = 3'sd1; end
      default: ;
    endcase
    if (half) begin
      dx = dx <<< 1;
      dy = dy <<< 1;
    end
    ox  = MVW'(dx);
    oy  = MVW'(dy);
    r.x = c.x + ox;
    r.y = c.y + oy;
    return r;
  endfunction

  state_t      state_q, state_d;
  mv_t         centre_q, centre_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  recv_cnt_q, recv_cnt_d;
  logic [15:0] min_cost_q, min_cost_d;
  mv_t         min_mv_q, min_mv_d;
  logic        cand_valid_q, cand_valid_d;
  mv_t         cand_mv_q, cand_mv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  mv_t         best_mv_q, best_mv_d;
  logic [15:0] best_cost_q, best_cost_d;

  logic        in_pass;
  logic        handshake;
  logic        take;
  logic        win;
  mv_t         rx_mv;
  mv_t         win_mv;
  logic [15:0] win_cost;

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    centre_d    = centre_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    min_cost_d  = min_cost_q;
    min_mv_d    = min_mv_q;
    best_mv_d   = best_mv_q;
    best_cost_d = best_cost_q;

    in_pass   = (state_q == HALF) || (state_q == QTR);
    handshake = in_pass && cand_valid_q && cand_ready;
    // A cost only counts against a candidate that was handed over on an earlier edge.
    take      = in_pass && cost_valid && (recv_cnt_q < NCAND) && (recv_cnt_q < issue_cnt_q);
    rx_mv     = cand_at(centre_q, state_q == HALF, recv_cnt_q);
    win       = take && ((recv_cnt_q == 4'd0) || (cost < min_cost_q));
    win_mv    = win ? rx_mv : min_mv_q;
    win_cost  = win ? cost  : min_cost_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          centre_d.x  = {int_mv_x, 2'b00};
          centre_d.y  = {int_mv_y, 2'b00};
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = HALF;
        end
      end
      HALF, QTR: begin
        if (handshake) issue_cnt_d = issue_cnt_q + 4'd1;
        if (take) begin
          min_cost_d = win_cost;
          min_mv_d   = win_mv;
          recv_cnt_d = recv_cnt_q + 4'd1;
          if (recv_cnt_q == NCAND - 4'd1) begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            if (state_q == HALF) begin
              centre_d = win_mv;
              state_d  = QTR;
            end else begin
              best_mv_d   = win_mv;
              best_cost_d = win_cost;
              state_d     = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    cand_valid_d = ((state_d == HALF) || (state_d == QTR)) && (issue_cnt_d < NCAND);
    cand_mv_d    = cand_at(centre_d, state_d == HALF, issue_cnt_d);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      centre_q     <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      min_cost_q   <= '0;
      min_mv_q     <= '0;
      cand_valid_q <= 1'b0;
      cand_mv_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_mv_q    <= '0;
      best_cost_q  <= '0;
    end else begin
      state_q      <= state_d;
      centre_q     <= centre_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      min_cost_q   <= min_cost_d;
      min_mv_q     <= min_mv_d;
      cand_valid_q <= cand_valid_d;
      cand_mv_q    <= cand_mv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_mv_q    <= best_mv_d;
      best_cost_q  <= best_cost_d;
    end
  end

  assign cand_valid = cand_valid_q;
  assign cand_mv_x  = cand_mv_q.x;
  assign cand_mv_y  = cand_mv_q.y;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_mv_x  = best_mv_q.x;
  assign best_mv_y  = best_mv_q.y;
  assign best_cost  = best_cost_q;

endmodule

// File: tb/tb_fme_refine_ctrl.sv
// Bench for fme_refine_ctrl: a cycle-stepped datapath responder plus a reference model
// that derives every candidate and the final winner from the offset table and cost list.
module tb_fme_refine_ctrl;

  localparam int MVW = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [MVW-3:0]    int_mv_x = '0;
  logic [MVW-3:0]    int_mv_y = '0;
  logic              cand_valid;
  logic              cand_ready = 1'b0;
  logic [MVW-1:0]    cand_mv_x;
  logic [MVW-1:0]    cand_mv_y;
  logic              cost_valid = 1'b0;
  logic [15:0]       cost = '0;
  logic              busy;
  logic              done;
  logic [MVW-1:0]    best_mv_x;
  logic [MVW-1:0]    best_mv_y;
  logic [15:0]       best_cost;

  fme_refine_ctrl #(.MVW(MVW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .int_mv_x   (int_mv_x),
    .int_mv_y   (int_mv_y),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_mv_x  (cand_mv_x),
    .cand_mv_y  (cand_mv_y),
    .cost_valid (cost_valid),
    .cost       (cost),
    .busy       (busy),
    .done       (done),
    .best_mv_x  (best_mv_x),
    .best_mv_y  (best_mv_y),
    .best_cost  (best_cost)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int dx_t[9] = '{-1, 0, 1, -1, 1, -1, 0, 1, 0};
  int dy_t[9] = '{-1, -1, -1, 0, 0, 1, 1, 1, 0};
  int cost_tab[18];   // costs returned in handshake order: HALF k=0..8, then QTR k=0..8

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vectors wrap modulo 2^MVW on the output ports.
  function automatic logic [31:0] m(input int v);
    return 32'(v) & ((32'd1 << MVW) - 32'd1);
  endfunction

  // First index holding the smallest cost of a pass.
  function automatic int argmin9(input int base);
    int b = 0;
    for (int k = 1; k < 9; k++)
      if (cost_tab[base + k] < cost_tab[base + b]) b = k;
    return b;
  endfunction

  // One full refinement: drives start, plays the datapath, checks candidates and the result.
  task automatic run(input int cx, input int cy, input int rdy_mode, input int lat,
                     input bit spur, input bit busy_start);
    int ex[18];
    int ey[18];
    int kh, kq, hs, rc, cyc;
    int due[$];
    bit r, pulsed;
    kh = argmin9(0);
    for (int k = 0; k < 9; k++) begin
      ex[k] = 4 * cx + 2 * dx_t[k];
      ey[k] = 4 * cy + 2 * dy_t[k];
    end
    for (int k = 0; k < 9; k++) begin
      ex[9 + k] = ex[kh] + dx_t[k];
      ey[9 + k] = ey[kh] + dy_t[k];
    end
    kq = argmin9(9);

    @(negedge clk);
    int_mv_x = (MVW-2)'(cx);
    int_mv_y = (MVW-2)'(cy);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cand_valid_after_start", cand_valid, 1);

    hs = 0; rc = 0; cyc = 0; pulsed = 1'b0;
    while (!done && cyc < 400) begin
      start      = 1'b0;
      cost_valid = 1'b0;
      cost       = '0;
      if (due.size() > 0 && due[0] <= cyc) begin
        cost_valid = 1'b1;
        cost       = 16'(cost_tab[rc]);
        void'(due.pop_front());
        rc++;
      end else if (spur && rc == hs) begin
        // Nothing outstanding: a zero cost here would win if it were wrongly taken.
        cost_valid = 1'b1;
        cost       = 16'd0;
      end
      if (busy_start && hs >= 10 && !pulsed) begin
        start    = 1'b1;
        int_mv_x = (MVW-2)'(cx + 7);
        int_mv_y = (MVW-2)'(cy - 3);
        pulsed   = 1'b1;
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      cand_ready = r;
      check("busy_in_run", busy, 1);
      if (cand_valid) begin
        if (hs < 18) begin
          check("cand_mv_x", cand_mv_x, m(ex[hs]));
          check("cand_mv_y", cand_mv_y, m(ey[hs]));
          if (r) begin
            due.push_back(cyc + 1 + int'($urandom_range(0, lat)));
            hs++;
          end
        end else begin
          check("cand_valid_extra", cand_valid, 0);
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    cand_ready = 1'b0;
    cost_valid = 1'b0;
    start      = 1'b0;

    check("done_seen", done, 1);
    check("handshakes", hs, 18);
    check("costs_sent", rc, 18);
    check("best_mv_x", best_mv_x, m(ex[9 + kq]));
    check("best_mv_y", best_mv_y, m(ey[9 + kq]));
    check("best_cost", best_cost, cost_tab[9 + kq]);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_pulse_len", done, 0);
    check("busy_after_done", busy, 0);
    check("cand_valid_idle", cand_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cand_valid"}, cand_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cand_mv_x"}, cand_mv_x, 0);
    check({tag, "_cand_mv_y"}, cand_mv_y, 0);
    check({tag, "_best_mv_x"}, best_mv_x, 0);
    check({tag, "_best_mv_y"}, best_mv_y, 0);
    check({tag, "_best_cost"}, best_cost, 0);
  endtask

  initial begin
    int n;
    int guard;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Reset in the middle of HALF after four handshakes.
    @(negedge clk);
    int_mv_x = (MVW-2)'(5);
    int_mv_y = (MVW-2)'(5);
    start    = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cand_ready = 1'b1;
    n = 0; guard = 0;
    while (n < 4 && guard < 20) begin
      if (cand_valid) n++;
      @(negedge clk);
      guard++;
    end
    check("hs_before_reset", n, 4);
    cand_ready = 1'b0;
    rst_n      = 1'b0;
    cost_valid = 1'b1;
    cost       = 16'd0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) cost_tab[i] = int'($urandom_range(1, 40));
    run(3, -2, 0, 0, 1'b1, 1'b0);

    // Nominal run.
    for (int i = 0; i < 18; i++) cost_tab[i] = (i < 9) ? 50 : 20;
    cost_tab[4]  = 10;
    cost_tab[10] = 7;
    run(0, 0, 0, 0, 1'b0, 1'b0);
    check("nom_best_x", best_mv_x, m(2));
    check("nom_best_y", best_mv_y, m(-1));
    check("nom_best_cost", best_cost, 7);

    // All costs equal: the lowest index wins both passes.
    for (int i = 0; i < 18; i++) cost_tab[i] = 100;
    run(0, 0, 0, 1, 1'b0, 1'b0);
    check("tie_best_x", best_mv_x, m(-3));
    check("tie_best_y", best_mv_y, m(-3));
    check("tie_best_cost", best_cost, 100);

    // Backpressure 1,0,0 with the nominal costs.
    for (int i = 0; i < 18; i++) cost_tab[i] = (i < 9) ? 50 : 20;
    cost_tab[4]  = 10;
    cost_tab[10] = 7;
    run(0, 0, 1, 2, 1'b0, 1'b0);
    check("bp_best_x", best_mv_x, m(2));
    check("bp_best_y", best_mv_y, m(-1));
    check("bp_best_cost", best_cost, 7);

    // Spurious costs before any handshake and after the last HALF cost.
    run(0, 0, 0, 0, 1'b1, 1'b0);
    check("spur_best_cost", best_cost, 7);

    // Boundary centre, start pulsed during QTR; the x result wraps in 12 bits.
    for (int i = 0; i < 18; i++) cost_tab[i] = 5;
    cost_tab[0] = 1;
    cost_tab[9] = 1;
    run(-512, 511, 0, 0, 1'b0, 1'b1);
    check("bnd_best_x", best_mv_x, m(-2051));
    check("bnd_best_y", best_mv_y, m(2041));
    check("bnd_best_cost", best_cost, 1);
    @(negedge clk);
    check("bnd_no_restart", busy, 0);

    // Randomised runs: costs, centre, ready pattern, cost latency, spurious pulses.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 18; i++)
        cost_tab[i] = (t % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 65535));
      run(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
